// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: state encodings,
// abort codes and the running checksum helper.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LEN_LO = 3'd1,
      ST_LEN_HI = 3'd2,
      ST_DATA   = 3'd3,
      ST_CSUM   = 3'd4,
      ST_DONE   = 3'd5,
      ST_ERR    = 3'd6
   } state_e;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_LEN     = 2'd1;
   localparam logic [1:0] ERR_CSUM    = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

   function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] b);
      return acc ^ b;
   endfunction

endpackage

// File: rtl/imem_loader_gap_timer.sv
// Idle-gap watchdog: counts cycles without an accepted byte while a frame is open.
// expired is raised during the TIMEOUT-th consecutive idle cycle.
module gap_timer #(
   parameter int TIMEOUT = 1000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic en,
   output logic expired
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] count_r;

   // Idle-cycle counter, saturating at the expiry value
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_r <= {CNT_W{1'b0}};
      end else if (clear) begin
         count_r <= {CNT_W{1'b0}};
      end else if (en && (count_r != LAST)) begin
         count_r <= count_r + CNT_W'(1);
      end
   end

   assign expired = en && (count_r == LAST);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed byte frame and writes
// the payload into instruction memory from address 0, releasing the core on success.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W  = 10,
   parameter int TIMEOUT = 1000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_byte,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [7:0]        imem_data,
   output logic [ADDR_W:0]   bytes_loaded,
   output logic              load_done,
   output logic              load_err,
   output logic [1:0]        err_code,
   output logic              cpu_run
);

   localparam logic [16:0]   CAPACITY = 17'(2 ** ADDR_W);
   localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);

   state_e              state_r, state_nxt_s;
   logic [7:0]          len_lo_r, len_lo_nxt_s;
   logic [ADDR_W:0]     len_r, len_nxt_s;
   logic [ADDR_W:0]     count_r, count_nxt_s, count_inc_s;
   logic [7:0]          csum_r, csum_nxt_s;
   logic [1:0]          err_r, err_nxt_s;
   logic                we_r, we_nxt_s;
   logic [ADDR_W-1:0]   addr_r, addr_nxt_s;
   logic [7:0]          data_r, data_nxt_s;
   logic                done_r, fail_r, run_r;
   logic [15:0]         len_full_s;
   logic                in_frame_s, accept_s, expired_s;

   assign in_frame_s  = (state_r == ST_LEN_LO) || (state_r == ST_LEN_HI) ||
                        (state_r == ST_DATA)   || (state_r == ST_CSUM);
   assign accept_s    = in_valid && in_frame_s;
   assign len_full_s  = {in_byte, len_lo_r};
   assign count_inc_s = count_r + CNT_ONE;

   gap_timer #(.TIMEOUT(TIMEOUT)) u_gap_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (accept_s || !in_frame_s),
      .en      (in_frame_s),
      .expired (expired_s)
   );

   // Next-state and datapath decode; an accept always beats a same-cycle timeout
   always_comb begin
      state_nxt_s  = state_r;
      len_lo_nxt_s = len_lo_r;
      len_nxt_s    = len_r;
      count_nxt_s  = count_r;
      csum_nxt_s   = csum_r;
      err_nxt_s    = err_r;
      we_nxt_s     = 1'b0;
      addr_nxt_s   = addr_r;
      data_nxt_s   = data_r;
      case (state_r)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (start) begin
               state_nxt_s  = ST_LEN_LO;
               len_lo_nxt_s = 8'h00;
               len_nxt_s    = {(ADDR_W + 1){1'b0}};
               count_nxt_s  = {(ADDR_W + 1){1'b0}};
               csum_nxt_s   = 8'h00;
               err_nxt_s    = ERR_NONE;
            end else begin
               state_nxt_s  = state_r;
            end
         end
         ST_LEN_LO: begin
            if (accept_s) begin
               len_lo_nxt_s = in_byte;
               state_nxt_s  = ST_LEN_HI;
            end else if (expired_s) begin
               state_nxt_s  = ST_ERR;
               err_nxt_s    = ERR_TIMEOUT;
            end else begin
               state_nxt_s  = ST_LEN_LO;
            end
         end
         ST_LEN_HI: begin
            if (accept_s) begin
               len_nxt_s = len_full_s[ADDR_W:0];
               if ({1'b0, len_full_s} > CAPACITY) begin
                  state_nxt_s = ST_ERR;
                  err_nxt_s   = ERR_LEN;
               end else if (len_full_s == 16'h0000) begin
                  state_nxt_s = ST_CSUM;
               end else begin
                  state_nxt_s = ST_DATA;
               end
            end else if (expired_s) begin
               state_nxt_s = ST_ERR;
               err_nxt_s   = ERR_TIMEOUT;
            end else begin
               state_nxt_s = ST_LEN_HI;
            end
         end
         ST_DATA: begin
            if (accept_s) begin
               we_nxt_s    = 1'b1;
               addr_nxt_s  = count_r[ADDR_W-1:0];
               data_nxt_s  = in_byte;
               csum_nxt_s  = csum_fold(csum_r, in_byte);
               count_nxt_s = count_inc_s;
               if (count_inc_s == len_r) begin
                  state_nxt_s = ST_CSUM;
               end else begin
                  state_nxt_s = ST_DATA;
               end
            end else if (expired_s) begin
               state_nxt_s = ST_ERR;
               err_nxt_s   = ERR_TIMEOUT;
            end else begin
               state_nxt_s = ST_DATA;
            end
         end
         ST_CSUM: begin
            if (accept_s) begin
               if (in_byte == csum_r) begin
                  state_nxt_s = ST_DONE;
               end else begin
                  state_nxt_s = ST_ERR;
                  err_nxt_s   = ERR_CSUM;
               end
            end else if (expired_s) begin
               state_nxt_s = ST_ERR;
               err_nxt_s   = ERR_TIMEOUT;
            end else begin
               state_nxt_s = ST_CSUM;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // State, counters, write port and status flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r  <= ST_IDLE;
         len_lo_r <= 8'h00;
         len_r    <= {(ADDR_W + 1){1'b0}};
         count_r  <= {(ADDR_W + 1){1'b0}};
         csum_r   <= 8'h00;
         err_r    <= ERR_NONE;
         we_r     <= 1'b0;
         addr_r   <= {ADDR_W{1'b0}};
         data_r   <= 8'h00;
         done_r   <= 1'b0;
         fail_r   <= 1'b0;
         run_r    <= 1'b0;
      end else begin
         state_r  <= state_nxt_s;
         len_lo_r <= len_lo_nxt_s;
         len_r    <= len_nxt_s;
         count_r  <= count_nxt_s;
         csum_r   <= csum_nxt_s;
         err_r    <= err_nxt_s;
         we_r     <= we_nxt_s;
         addr_r   <= addr_nxt_s;
         data_r   <= data_nxt_s;
         done_r   <= (state_nxt_s == ST_DONE);
         fail_r   <= (state_nxt_s == ST_ERR);
         run_r    <= (state_nxt_s == ST_DONE);
      end
   end

   assign in_ready     = in_frame_s;
   assign imem_we      = we_r;
   assign imem_addr    = addr_r;
   assign imem_data    = data_r;
   assign bytes_loaded = count_r;
   assign load_done    = done_r;
   assign load_err     = fail_r;
   assign err_code     = err_r;
   assign cpu_run      = run_r;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader (ADDR_W=10, TIMEOUT=1000).
module tb_imem_loader;

   localparam int ADDR_W  = 10;
   localparam int TIMEOUT = 1000;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic              in_valid = 1'b0;
   logic [7:0]        in_byte = 8'h00;
   logic              in_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [7:0]        imem_data;
   logic [ADDR_W:0]   bytes_loaded;
   logic              load_done;
   logic              load_err;
   logic [1:0]        err_code;
   logic              cpu_run;

   int checks = 0;
   int errors = 0;
   int wr_cnt = 0;
   int base;
   logic bad_we = 1'b0;
   logic [7:0] mem [0:(1 << ADDR_W) - 1];
   logic [7:0] exp_mem [0:(1 << ADDR_W) - 1];

   imem_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_byte(in_byte),
      .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_data(imem_data),
      .bytes_loaded(bytes_loaded), .load_done(load_done), .load_err(load_err),
      .err_code(err_code), .cpu_run(cpu_run)
   );

   always #5 clk = ~clk;

   // Shadow instruction memory and write counter
   always @(posedge clk) begin
      if (imem_we) begin
         mem[imem_addr] <= imem_data;
         wr_cnt         <= wr_cnt + 1;
      end
      if (rst && imem_we) bad_we <= 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      in_valid = 1'b1;
      in_byte  = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] cs;
      logic [7:0] b;
      int mism;

      idle(3);
      rst = 1'b0;
      idle(1);
      check("rst_ready", in_ready, 0);
      check("rst_we", imem_we, 0);
      check("rst_bytes", bytes_loaded, 0);
      check("rst_flags", {load_done, load_err, err_code, cpu_run}, 0);

      // Bytes offered outside a frame are ignored
      send_byte(8'h55);
      idle(2);
      check("idle_ignore", {in_ready, bytes_loaded, load_err}, 0);

      // Good 3-byte frame; payload XOR 30^F0^10 = D0
      base = wr_cnt;
      pulse_start();
      check("lenlo_ready", in_ready, 1);
      send_byte(8'h03);
      send_byte(8'h00);
      send_byte(8'h30);
      check("wr0_port", {imem_we, 6'(imem_addr), imem_data}, {1'b1, 6'd0, 8'h30});
      send_byte(8'hF0);
      send_byte(8'h10);
      send_byte(8'hD0);
      check("good_done", {load_done, cpu_run, load_err, err_code}, {1'b1, 1'b1, 1'b0, 2'd0});
      check("good_bytes", bytes_loaded, 3);
      check("good_writes", wr_cnt - base, 3);
      check("good_mem", {mem[0], mem[1], mem[2]}, 24'h30F010);
      check("done_not_ready", in_ready, 0);
      idle(5);
      check("done_held", {load_done, cpu_run}, 2'b11);

      // Restart from DONE drops cpu_run next cycle; bad checksum aborts
      base = wr_cnt;
      pulse_start();
      check("restart_run", {cpu_run, load_done, bytes_loaded}, 0);
      send_byte(8'h03); send_byte(8'h00);
      send_byte(8'h30); send_byte(8'hF0); send_byte(8'h10);
      send_byte(8'h00);
      check("csum_err", {load_err, err_code, cpu_run, load_done}, {1'b1, 2'd2, 1'b0, 1'b0});
      check("csum_writes", wr_cnt - base, 3);

      // Oversized length 0x0401
      base = wr_cnt;
      pulse_start();
      send_byte(8'h01);
      send_byte(8'h04);
      check("len_err", {load_err, err_code, cpu_run}, {1'b1, 2'd1, 1'b0});
      idle(2);
      check("len_writes", wr_cnt - base, 0);

      // Reset mid-DATA
      pulse_start();
      send_byte(8'h05); send_byte(8'h00);
      send_byte(8'h11); send_byte(8'h22);
      rst = 1'b1;
      #1;
      check("midrst_out", {imem_we, bytes_loaded, load_done, load_err, err_code, cpu_run, in_ready}, 0);
      base = wr_cnt;
      idle(3);
      rst = 1'b0;
      idle(2);
      check("midrst_idle", {in_ready, bytes_loaded, cpu_run}, 0);
      check("midrst_nowe", {bad_we, 8'(wr_cnt - base)}, 0);

      // Timeout after one payload byte
      base = wr_cnt;
      pulse_start();
      send_byte(8'h02); send_byte(8'h00);
      send_byte(8'h5A);
      idle(TIMEOUT - 1);
      check("to_not_yet", load_err, 0);
      idle(1);
      check("to_err", {load_err, err_code, cpu_run}, {1'b1, 2'd3, 1'b0});
      check("to_writes", {bytes_loaded, 8'(wr_cnt - base)}, {11'd1, 8'd1});

      // Byte arriving in the last permitted idle cycle; start mid-frame ignored
      pulse_start();
      send_byte(8'h02); send_byte(8'h00);
      send_byte(8'hAA);
      idle(TIMEOUT - 2);
      start = 1'b1;
      send_byte(8'hBB);
      start = 1'b0;
      check("late_ok", {load_err, bytes_loaded}, {1'b0, 11'd2});
      send_byte(8'h11);
      check("late_done", {load_done, cpu_run, mem[0], mem[1]}, {1'b1, 1'b1, 8'hAA, 8'hBB});

      // Full-capacity frame with random gaps
      base = wr_cnt;
      pulse_start();
      send_byte(8'h00); send_byte(8'h04);
      cs = 8'h00;
      for (int i = 0; i < (1 << ADDR_W); i++) begin
         b = 8'(i * 7 + 3) ^ 8'(i >> 8);
         exp_mem[i] = b;
         cs = cs ^ b;
         idle($urandom_range(0, 3));
         send_byte(b);
      end
      idle($urandom_range(0, 3));
      send_byte(cs);
      check("big_done", {load_done, cpu_run, load_err}, 3'b110);
      check("big_bytes", bytes_loaded, 1024);
      check("big_writes", wr_cnt - base, 1024);
      mism = 0;
      for (int i = 0; i < (1 << ADDR_W); i++) begin
         if (mem[i] !== exp_mem[i]) mism++;
      end
      check("big_mem", mism, 0);

      pulse_start();
      check("big_restart", {cpu_run, load_done, bytes_loaded}, 0);
      send_byte(8'h01); send_byte(8'h00);
      send_byte(8'h77); send_byte(8'h77);
      check("reload", {load_done, cpu_run, bytes_loaded, mem[0]}, {1'b1, 1'b1, 11'd1, 8'h77});

      // Empty payload: checksum 00
      base = wr_cnt;
      pulse_start();
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      check("empty", {load_done, bytes_loaded, 8'(wr_cnt - base)}, {1'b1, 11'd0, 8'd0});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
